// File: rtl/control_sequencer.sv
// Moore-style hardwired control unit: steps fetch (T0-T2) and register-register execute
// (T3-T6) for one instruction at a time, driving the datapath load/drive/ALU strobes.
module control_sequencer #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 Run,
    input  logic                 Stop,
    input  logic                 MemRdy,
    input  logic [BITS-1:0]      IRVal,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 PCout,
    output logic                 MDRout,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 PCin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 RZin,
    output logic                 MARin,
    output logic                 MDRin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 Read,
    output logic                 IncPC,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 AND,
    output logic                 OR,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 Halted,
    output logic                 Busy
);

    localparam logic [3:0] IDLE = 4'd0;
    localparam logic [3:0] T0   = 4'd1;
    localparam logic [3:0] T1   = 4'd2;
    localparam logic [3:0] T2   = 4'd3;
    localparam logic [3:0] T3   = 4'd4;
    localparam logic [3:0] T4   = 4'd5;
    localparam logic [3:0] T5   = 4'd6;
    localparam logic [3:0] T6   = 4'd7;
    localparam logic [3:0] HALT = 4'd8;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_AND  = 5'd2;
    localparam logic [4:0] OP_OR   = 5'd3;
    localparam logic [4:0] OP_SHR  = 5'd4;
    localparam logic [4:0] OP_SHL  = 5'd5;
    localparam logic [4:0] OP_ROR  = 5'd6;
    localparam logic [4:0] OP_ROL  = 5'd7;
    localparam logic [4:0] OP_MUL  = 5'd8;
    localparam logic [4:0] OP_DIV  = 5'd9;
    localparam logic [4:0] OP_NEG  = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_HALT = 5'd31;

    logic [3:0] state_q, state_d;
    logic       stop_q, stop_d;
    logic [4:0] op_q;
    logic [3:0] ra_q, rb_q, rc_q;

    logic regs_ok;
    logic op_known;
    logic op_legal;
    logic op_unary;
    logic op_long;
    logic stop_pend;
    logic [3:0] end_state;
    logic unused_ir;

    // Bits of IRVal outside the decoded fields carry no control information.
    assign unused_ir = ^IRVal;

    if (REGISTERS >= 16) begin : g_all_regs
        assign regs_ok = 1'b1;
    end else begin : g_reg_chk
        assign regs_ok = (int'(ra_q) < REGISTERS) && (int'(rb_q) < REGISTERS)
                      && (int'(rc_q) < REGISTERS);
    end

    assign op_known  = (op_q <= OP_NOT);
    assign op_legal  = op_known && regs_ok;
    assign op_unary  = (op_q == OP_NEG) || (op_q == OP_NOT);
    assign op_long   = (op_q == OP_MUL) || (op_q == OP_DIV);
    assign stop_pend = stop_q || Stop;
    assign end_state = stop_pend ? HALT : (Run ? T0 : IDLE);

    function automatic logic [REGISTERS-1:0] onehot(input logic [3:0] idx);
        onehot = {{(REGISTERS-1){1'b0}}, 1'b1} << idx;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (stop_pend) begin
                    state_d = HALT;
                end else if (Run) begin
                    state_d = T0;
                end
            end
            T0: state_d = T1;
            T1: state_d = MemRdy ? T2 : T1;
            T2: state_d = T3;
            T3: state_d = (op_legal && op_q != OP_HALT) ? T4 : HALT;
            T4: state_d = T5;
            T5: state_d = op_long ? T6 : end_state;
            T6: state_d = end_state;
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // A pending Stop is consumed by the transition into HALT.
    assign stop_d = (state_d == HALT) ? 1'b0 : stop_pend;

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            // Fields are captured on the edge into T3 so T3 outputs decode from registers only.
            if (state_q == T2) begin
                op_q <= IRVal[31:27];
                ra_q <= IRVal[26:23];
                rb_q <= IRVal[22:19];
                rc_q <= IRVal[18:15];
            end
        end
    end

    always_comb begin
        GPRin    = '0;
        GPRout   = '0;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        PCin     = 1'b0;
        IRin     = 1'b0;
        RYin     = 1'b0;
        RZin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        IncPC    = 1'b0;
        ADD      = 1'b0;
        SUB      = 1'b0;
        MUL      = 1'b0;
        DIV      = 1'b0;
        SHR      = 1'b0;
        SHL      = 1'b0;
        ROR      = 1'b0;
        ROL      = 1'b0;
        AND      = 1'b0;
        OR       = 1'b0;
        NEGATE   = 1'b0;
        NOT      = 1'b0;
        Halted   = 1'b0;
        Busy     = 1'b0;
        case (state_q)
            T0: begin
                Busy  = 1'b1;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                RZin  = 1'b1;
            end
            T1: begin
                Busy    = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                Busy   = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                Busy = 1'b1;
                if (op_legal) begin
                    GPRout = onehot(rb_q);
                    RYin   = 1'b1;
                end
            end
            T4: begin
                Busy   = 1'b1;
                RZin   = 1'b1;
                GPRout = op_unary ? onehot(rb_q) : onehot(rc_q);
                case (op_q)
                    OP_ADD:  ADD    = 1'b1;
                    OP_SUB:  SUB    = 1'b1;
                    OP_AND:  AND    = 1'b1;
                    OP_OR:   OR     = 1'b1;
                    OP_SHR:  SHR    = 1'b1;
                    OP_SHL:  SHL    = 1'b1;
                    OP_ROR:  ROR    = 1'b1;
                    OP_ROL:  ROL    = 1'b1;
                    OP_MUL:  MUL    = 1'b1;
                    OP_DIV:  DIV    = 1'b1;
                    OP_NEG:  NEGATE = 1'b1;
                    OP_NOT:  NOT    = 1'b1;
                    default: ;
                endcase
            end
            T5: begin
                Busy    = 1'b1;
                Zlowout = 1'b1;
                if (op_long) begin
                    LOin = 1'b1;
                end else begin
                    GPRin = onehot(ra_q);
                end
            end
            T6: begin
                Busy     = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            HALT: Halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle strobe words are queued as each
// instruction is launched and compared one per clock, sampled 1 time unit after the edge.
module tb_control_sequencer;

    logic        Clock, reset, Run, Stop, MemRdy;
    logic [31:0] IRVal;
    logic [15:0] GPRin, GPRout;
    logic PCout, MDRout, Zlowout, Zhighout, PCin, IRin, RYin, RZin, MARin, MDRin;
    logic HIin, LOin, Read, IncPC, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR;
    logic NEGATE, NOT, Halted, Busy;

    typedef struct packed {
        logic [27:0] ctl;
        logic [15:0] gin;
        logic [15:0] gout;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    control_sequencer dut (
        .Clock(Clock), .reset(reset), .Run(Run), .Stop(Stop), .MemRdy(MemRdy), .IRVal(IRVal),
        .GPRin(GPRin), .GPRout(GPRout), .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .PCin(PCin), .IRin(IRin), .RYin(RYin), .RZin(RZin),
        .MARin(MARin), .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Read(Read), .IncPC(IncPC),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL), .ROR(ROR),
        .ROL(ROL), .AND(AND), .OR(OR), .NEGATE(NEGATE), .NOT(NOT), .Halted(Halted),
        .Busy(Busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [27:0] b(input int k);
        return 28'(1) << k;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        return 16'(1) << i;
    endfunction

    function automatic exp_t mk(input logic [27:0] c, input logic [15:0] gi, input logic [15:0] go);
        exp_t e;
        e.ctl  = c;
        e.gin  = gi;
        e.gout = go;
        return e;
    endfunction

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {5'(op), 4'(ra), 4'(rb), 4'(rc), 15'd0};
    endfunction

    // Bit index of each op's ALU strobe in the observed control word.
    function automatic int alu_bit(input logic [4:0] op);
        case (op)
            5'd0: return 13;  5'd1: return 12;  5'd2: return 5;   5'd3: return 4;
            5'd4: return 9;   5'd5: return 8;   5'd6: return 7;   5'd7: return 6;
            5'd8: return 11;  5'd9: return 10;  5'd10: return 3;  default: return 2;
        endcase
    endfunction

    function automatic exp_t observe();
        return mk({PCout, MDRout, Zlowout, Zhighout, PCin, IRin, RYin, RZin, MARin, MDRin,
                   HIin, LOin, Read, IncPC, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR,
                   NEGATE, NOT, Halted, Busy}, GPRin, GPRout);
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge Clock);
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("cyc%0d", cyc), 64'(observe()), 64'(e));
        end
    endtask

    task automatic push_idle(input int n);
        repeat (n) exp_q.push_back(mk('0, '0, '0));
    endtask

    task automatic push_halt(input int n);
        repeat (n) exp_q.push_back(mk(b(1), '0, '0));
    endtask

    // Queue the whole expected trace of one instruction, ending in IDLE or HALT.
    task automatic push_instr(input logic [31:0] ir, input int waits, input bit stop);
        logic [4:0] op = ir[31:27];
        logic [3:0] ra = ir[26:23];
        logic [3:0] rb = ir[22:19];
        logic [3:0] rc = ir[18:15];
        bit legal = (op <= 5'd11);
        bit unary = (op == 5'd10) || (op == 5'd11);
        bit long_op = (op == 5'd8) || (op == 5'd9);
        exp_q.push_back(mk(b(27) | b(19) | b(14) | b(20) | b(0), '0, '0));
        repeat (waits + 1) exp_q.push_back(mk(b(25) | b(23) | b(15) | b(18) | b(0), '0, '0));
        exp_q.push_back(mk(b(26) | b(22) | b(0), '0, '0));
        if (!legal) begin
            exp_q.push_back(mk(b(0), '0, '0));
            push_halt(1);
        end else begin
            exp_q.push_back(mk(b(21) | b(0), '0, oh(rb)));
            exp_q.push_back(mk(b(alu_bit(op)) | b(20) | b(0), '0, unary ? oh(rb) : oh(rc)));
            if (long_op) begin
                exp_q.push_back(mk(b(25) | b(16) | b(0), '0, '0));
                exp_q.push_back(mk(b(24) | b(17) | b(0), '0, '0));
            end else begin
                exp_q.push_back(mk(b(25) | b(0), oh(ra), '0));
            end
            if (stop) push_halt(1);
            else push_idle(1);
        end
    endtask

    // Launch one instruction from IDLE and run until its expected trace is consumed.
    task automatic exec(input logic [31:0] ir, input int waits, input bit stop_t3);
        IRVal  = ir;
        Stop   = 1'b0;
        Run    = 1'b1;
        MemRdy = (waits == 0);
        push_instr(ir, waits, stop_t3 && (ir[31:27] <= 5'd11));
        tick();
        Run = 1'b0;
        tick();
        for (int k = 1; k <= waits + 1; k++) begin
            MemRdy = (k == waits + 1);
            tick();
        end
        tick();
        if (stop_t3) Stop = 1'b1;
        tick();
        Stop = 1'b0;
        while (exp_q.size() > 0) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Run   = 1'b0;
        Stop  = 1'b0;
        push_idle(1);
        tick();
        reset = 1'b0;
        push_idle(1);
        tick();
    endtask

    initial begin
        reset  = 1'b1;
        Run    = 1'b0;
        Stop   = 1'b0;
        MemRdy = 1'b0;
        IRVal  = '0;
        push_idle(2);
        repeat (2) tick();
        reset = 1'b0;
        push_idle(2);
        repeat (2) tick();

        exec(mk_ir(0, 2, 3, 4), 0, 1'b0);
        exec(mk_ir(0, 2, 3, 4), 3, 1'b0);
        exec(mk_ir(1, 1, 1, 1), 2, 1'b0);
        exec(mk_ir(8, 0, 5, 6), 0, 1'b0);
        exec(mk_ir(9, 7, 2, 15), 1, 1'b0);
        exec(mk_ir(10, 5, 7, 0), 0, 1'b0);
        exec(mk_ir(11, 14, 9, 3), 0, 1'b0);
        exec(mk_ir(6, 15, 0, 8), 0, 1'b0);

        // Stop during T3 completes the instruction, then HALT holds despite Run.
        exec(mk_ir(2, 4, 5, 6), 0, 1'b1);
        Run = 1'b1;
        push_halt(3);
        repeat (3) tick();
        do_reset();

        exec(mk_ir(12, 1, 2, 3), 0, 1'b0);
        push_halt(2);
        repeat (2) tick();
        do_reset();

        exec(mk_ir(31, 0, 0, 0), 1, 1'b0);
        do_reset();

        Stop = 1'b1;
        Run  = 1'b1;
        push_halt(1);
        tick();
        Stop = 1'b0;
        push_halt(1);
        tick();
        do_reset();

        // Reset inside a T1 wait drops the instruction and any pending Stop.
        IRVal  = mk_ir(0, 2, 3, 4);
        MemRdy = 1'b0;
        Run    = 1'b1;
        exp_q.push_back(mk(b(27) | b(19) | b(14) | b(20) | b(0), '0, '0));
        repeat (2) exp_q.push_back(mk(b(25) | b(23) | b(15) | b(18) | b(0), '0, '0));
        push_idle(1);
        tick();
        Run = 1'b0;
        tick();
        Stop = 1'b1;
        tick();
        Stop  = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exec(mk_ir(0, 2, 3, 4), 0, 1'b0);

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
